// File: rtl/rca_arbiter.sv
// Round-robin arbiter/sequencer sharing one external 4-bit ripple-carry adder between two requesters.
// Optional saturating overflow counter on port ovf_cnt, enabled by defining RCA_ARB_OVF_CNT_EN.
module rca_arbiter #(
   parameter int WIDTH      = 4,
   parameter bit FIRST_PRIO = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             op0,
   input  logic             op1,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] sum,
   output logic             ovf,
   output logic             rsp_id,
   output logic             busy,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_op,
`ifdef RCA_ARB_OVF_CNT_EN
   output logic [7:0]       ovf_cnt,
`endif
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_ovf
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] RESP = 2'b10;

   logic [1:0]              state_q, state_d;
   logic                    last_q, last_d;
   logic                    gnt_q, gnt_d;
   logic signed [WIDTH-1:0] cap_a_q, cap_a_d;
   logic signed [WIDTH-1:0] cap_b_q, cap_b_d;
   logic                    cap_op_q, cap_op_d;
   logic signed [WIDTH-1:0] sum_q, sum_d;
   logic                    ovf_q, ovf_d;
   logic                    rsp_id_q, rsp_id_d;
   logic                    win;

   // On a tie the requester that was not served last wins; otherwise the lone requester wins.
   assign win = (req0 & req1) ? ~last_q : req1;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      cap_a_d  = cap_a_q;
      cap_b_d  = cap_b_q;
      cap_op_d = cap_op_q;
      sum_d    = sum_q;
      ovf_d    = ovf_q;
      rsp_id_d = rsp_id_q;
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d  = EXEC;
               gnt_d    = win;
               last_d   = win;
               cap_a_d  = win ? a1 : a0;
               cap_b_d  = win ? b1 : b0;
               cap_op_d = win ? op1 : op0;
            end
         end
         EXEC: begin
            state_d  = RESP;
            sum_d    = add_sum;
            ovf_d    = add_ovf;
            rsp_id_d = gnt_q;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture / result stage boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_q   <= ~FIRST_PRIO;
         gnt_q    <= 1'b0;
         cap_a_q  <= '0;
         cap_b_q  <= '0;
         cap_op_q <= 1'b0;
         sum_q    <= '0;
         ovf_q    <= 1'b0;
         rsp_id_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         cap_a_q  <= cap_a_d;
         cap_b_q  <= cap_b_d;
         cap_op_q <= cap_op_d;
         sum_q    <= sum_d;
         ovf_q    <= ovf_d;
         rsp_id_q <= rsp_id_d;
      end
   end

   assign add_a  = cap_a_q;
   assign add_b  = cap_b_q;
   assign add_op = cap_op_q;
   assign sum    = sum_q;
   assign ovf    = ovf_q;
   assign rsp_id = rsp_id_q;
   assign busy   = (state_q == EXEC) | (state_q == RESP);
   assign ack0   = (state_q == RESP) & ~gnt_q;
   assign ack1   = (state_q == RESP) & gnt_q;

`ifdef RCA_ARB_OVF_CNT_EN
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if ((state_q == EXEC) && add_ovf) begin
         ovf_cnt_d = sat_inc(ovf_cnt_q);
      end
   end

   // Overflow counter stage boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_q <= 8'd0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_rca_arbiter.sv
// Self-checking bench for rca_arbiter: behavioural adder, transaction-level reference model, directed + random steps.
module tb_rca_arbiter;
   localparam bit FIRST_PRIO = 1'b0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic       op0 = 1'b0, op1 = 1'b0;
   logic       ack0, ack1, ovf, rsp_id, busy, add_op, add_ovf;
   logic [3:0] sum, add_a, add_b, add_sum;
`ifdef RCA_ARB_OVF_CNT_EN
   logic [7:0] ovf_cnt;
`endif

   rca_arbiter #(.WIDTH(4), .FIRST_PRIO(FIRST_PRIO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .op0(op0), .op1(op1),
      .ack0(ack0), .ack1(ack1),
      .sum(sum), .ovf(ovf), .rsp_id(rsp_id), .busy(busy),
      .add_a(add_a), .add_b(add_b), .add_op(add_op),
`ifdef RCA_ARB_OVF_CNT_EN
      .ovf_cnt(ovf_cnt),
`endif
      .add_sum(add_sum), .add_ovf(add_ovf)
   );

   always #5 clk = ~clk;

   // Stand-in for the shared ripple-carry adder.
   logic [3:0] bx;
   logic [4:0] full;
   assign bx      = add_b ^ {4{add_op}};
   assign full    = {1'b0, add_a} + {1'b0, bx} + {4'b0, add_op};
   assign add_sum = full[3:0];
   assign add_ovf = (add_a[3] == bx[3]) && (full[3] != add_a[3]);

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: one transaction occupies three edges (grant, result, return to idle).
   int         m_phase;
   bit         m_last, m_win;
   logic [3:0] e_sum, e_add_a, e_add_b;
   logic       e_ovf, e_id, e_ack0, e_ack1, e_busy, e_add_op;
   int         e_cnt;

   function automatic int sval(input logic [3:0] v);
      return v[3] ? int'(v) - 16 : int'(v);
   endfunction

   task automatic model_reset();
      m_phase = 0; m_last = !FIRST_PRIO; m_win = 1'b0;
      e_sum = '0; e_add_a = '0; e_add_b = '0;
      e_ovf = 0; e_id = 0; e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_add_op = 0;
      e_cnt = 0;
   endtask

   task automatic model_edge();
      int r;
      e_ack0 = 0; e_ack1 = 0;
      if (m_phase == 0) begin
         if (req0 || req1) begin
            m_win    = (req0 && req1) ? !m_last : req1;
            m_last   = m_win;
            e_add_a  = m_win ? a1 : a0;
            e_add_b  = m_win ? b1 : b0;
            e_add_op = m_win ? op1 : op0;
            e_busy   = 1;
            m_phase  = 1;
         end else begin
            e_busy = 0;
         end
      end else if (m_phase == 1) begin
         r      = e_add_op ? sval(e_add_a) - sval(e_add_b) : sval(e_add_a) + sval(e_add_b);
         e_sum  = 4'(r & 15);
         e_ovf  = (r > 7) || (r < -8);
         e_id   = m_win;
         e_ack0 = !m_win;
         e_ack1 = m_win;
         if (e_ovf && e_cnt < 255) e_cnt++;
         m_phase = 2;
      end else begin
         e_busy  = 0;
         m_phase = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("ack0",   8'(ack0),   8'(e_ack0));
      chk("ack1",   8'(ack1),   8'(e_ack1));
      chk("busy",   8'(busy),   8'(e_busy));
      chk("sum",    8'(sum),    8'(e_sum));
      chk("ovf",    8'(ovf),    8'(e_ovf));
      chk("rsp_id", 8'(rsp_id), 8'(e_id));
      chk("add_a",  8'(add_a),  8'(e_add_a));
      chk("add_b",  8'(add_b),  8'(e_add_b));
      chk("add_op", 8'(add_op), 8'(e_add_op));
`ifdef RCA_ARB_OVF_CNT_EN
      chk("ovf_cnt", ovf_cnt, 8'(e_cnt));
`endif
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
      cyc++;
   endtask

   task automatic do_op(input bit id, input logic [3:0] a, input logic [3:0] b, input logic op,
                        input logic [3:0] xs, input logic xo);
      bit seen = 0;
      if (id) begin req1 = 1; a1 = a; b1 = b; op1 = op; end
      else    begin req0 = 1; a0 = a; b0 = b; op0 = op; end
      for (int n = 0; n < 8 && !seen; n++) begin
         step();
         if (id ? e_ack1 : e_ack0) begin
            seen = 1;
            chk("dir_sum", 8'(sum), 8'(xs));
            chk("dir_ovf", 8'(ovf), 8'(xo));
            chk("dir_rsp_id", 8'(rsp_id), 8'(id));
         end
      end
      chk("dir_ack_seen", 8'(seen), 8'd1);
      if (id) req1 = 0; else req0 = 0;
   endtask

   initial begin
      int ord[4];
      int ocyc[4];
      int nack;
      logic [3:0] exp_order;

      // Reset state
      model_reset();
      #12;
      check_all();
      rst_n = 1;

      // Tie from reset: both requesters held, service must alternate starting at FIRST_PRIO
      for (int i = 0; i < 4; i++) begin ord[i] = -1; ocyc[i] = -100; end
      nack = 0;
      req0 = 1; req1 = 1;
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = 1'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); op1 = 1'($urandom);
      for (int i = 0; i < 20 && nack < 4; i++) begin
         step();
         if (ack0 || ack1) begin
            ord[nack]  = ack1 ? 1 : 0;
            ocyc[nack] = cyc;
            nack++;
         end
         if (e_ack0) begin a0 = 4'($urandom); b0 = 4'($urandom); op0 = 1'($urandom); end
         if (e_ack1) begin a1 = 4'($urandom); b1 = 4'($urandom); op1 = 1'($urandom); end
      end
      req0 = 0; req1 = 0;
      chk("tie_count", 8'(nack), 8'd4);
      exp_order = 4'b1010;
      for (int i = 0; i < 4; i++) chk("tie_order", 8'(ord[i]), 8'(exp_order[i]));
      for (int i = 1; i < 4; i++) chk("tie_gap", 8'(ocyc[i] - ocyc[i-1]), 8'd3);
      step();

      // Directed operations
      do_op(0, 4'b0100, 4'b0011, 1'b0, 4'b0111, 1'b0);
      step();
      do_op(1, 4'b0111, 4'b0010, 1'b0, 4'b1001, 1'b1);
      step();
      do_op(0, 4'b1011, 4'b0100, 1'b1, 4'b0111, 1'b1);
      step();
      do_op(0, 4'b1011, 4'b1100, 1'b1, 4'b1111, 1'b0);
      step();

      // Reset during EXEC discards the operation
      req0 = 1; a0 = 4'b0101; b0 = 4'b0001; op0 = 0;
      step();
      chk("midrst_busy_before", 8'(busy), 8'd1);
      #2;
      rst_n = 0;
      model_reset();
      #1;
      check_all();
      req0 = 0;
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1;
      do_op(1, 4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0);
      step();

      // Randomized traffic obeying the requester rule
      for (int i = 0; i < 300; i++) begin
         step();
         if (req0 && e_ack0) begin
            if ($urandom_range(1, 0) == 0) req0 = 0;
            else begin a0 = 4'($urandom); b0 = 4'($urandom); op0 = 1'($urandom); end
         end else if (!req0 && $urandom_range(2, 0) == 0) begin
            req0 = 1; a0 = 4'($urandom); b0 = 4'($urandom); op0 = 1'($urandom);
         end
         if (req1 && e_ack1) begin
            if ($urandom_range(1, 0) == 0) req1 = 0;
            else begin a1 = 4'($urandom); b1 = 4'($urandom); op1 = 1'($urandom); end
         end else if (!req1 && $urandom_range(2, 0) == 0) begin
            req1 = 1; a1 = 4'($urandom); b1 = 4'($urandom); op1 = 1'($urandom);
         end
      end

`ifdef RCA_ARB_OVF_CNT_EN
      // Saturation: a long run of 7+2 overflows
      req0 = 0;
      req1 = 1; a1 = 4'd7; b1 = 4'd2; op1 = 0;
      for (int i = 0; i < 800; i++) step();
      req1 = 0;
      for (int i = 0; i < 4; i++) step();
      chk("ovf_cnt_sat", ovf_cnt, 8'd255);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rca_arbiter.md
# rca_arbiter

Round-robin arbiter and sequencer that shares one 4-bit `ripple_carry_adder` between two requesters. It captures the winning requester's operands and drives them into the adder. It then registers the adder's `Sum`/`overflow` and returns them to the winner with a one-cycle acknowledge. It sits between the two client blocks and a single adder instance at the top level.

## Interface
- `WIDTH`, 4: operand/result width; fixed to match the adder, no other value supported.
- `FIRST_PRIO`, 0: requester that wins the first tie after reset (0 or 1).

- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req0`, `req1` input 1: request level, held high with operands stable until the matching ack.
- `a0`, `b0`, `a1`, `b1` input 4: two's-complement operands per requester.
- `op0`, `op1` input 1: 0 = A+B, 1 = A−B.
- `ack0`, `ack1` output 1: one-cycle pulse, result valid for that requester.
- `sum` output 4: registered result of the last completed operation.
- `ovf` output 1: registered signed overflow of the last completed operation.
- `rsp_id` output 1: requester index of the last completed operation.
- `busy` output 1: high in EXEC and RESP.
- `add_a`, `add_b` output 4: to adder `A`, `B`.
- `add_op` output 1: to adder `op`.
- `add_sum` input 4: from adder `Sum`.
- `add_ovf` input 1: from adder `overflow`.
- `ovf_cnt` output 8: present only with `RCA_ARB_OVF_CNT_EN`; see Configuration.

## Operation
- **State machine:** states IDLE, EXEC, RESP.
  - IDLE → EXEC when `req0 | req1` is high at the clock edge.
  - EXEC → RESP unconditionally.
  - RESP → IDLE unconditionally.
- **Arbitration in IDLE:** evaluated at the sampling edge.
  - A single request wins.
  - When both requests are high, the requester not served last wins.
  - The `last` pointer resets to `~FIRST_PRIO`, so `FIRST_PRIO` wins the first tie.
- **Capture:** on the IDLE→EXEC edge, the winner's `a`/`b`/`op` are loaded into capture registers, and the winner index is latched as `gnt`. `last` is updated to `gnt`.
- **Adder drive:** `add_a`/`add_b`/`add_op` come directly from the capture registers. They change only on capture, so the adder inputs are stable for the whole EXEC cycle.
- **Result:** on the EXEC→RESP edge, the block registers `add_sum` into `sum`, `add_ovf` into `ovf`, and `gnt` into `rsp_id`.
- **Acknowledge:** `ack[gnt]` is high for exactly the RESP cycle. The other ack stays low.
- **Requester rule:** at the edge where it sees its ack, a requester either drops `req` or presents new operands with `req` held high.
  - A `req` still high in IDLE is a new request.
- **Hold:** `sum`/`ovf`/`rsp_id` keep their values until the next completion.
- **Arithmetic:** the block performs no arithmetic itself; results are the adder's 4-bit wrap-around values and signed overflow.
- **Ignored inputs:** a request that drops during EXEC/RESP is ignored. The captured operation completes and is acknowledged anyway.

## Timing
- **Latency:** request sampled at edge k (IDLE), adder evaluates during cycle k+1 (EXEC), result and ack valid in cycle k+2 (RESP).
- **Throughput:** one operation per 3 cycles. With both requesters continuously requesting, service alternates 0,1,0,1…
- **Reset values:** `ack0`=`ack1`=0, `sum`=0, `ovf`=0, `rsp_id`=0, `busy`=0, `add_a`=`add_b`=0, `add_op`=0, `ovf_cnt`=0. State is IDLE.
- **Reset mid-operation:** any in-flight operation is discarded with no ack. After `rst_n` deasserts, arbitration restarts from the reset value of `last`.
- No combinational path from `req*`/`a*`/`b*` to any output.

## Configuration
- Macro `RCA_ARB_OVF_CNT_EN`.
- **Defined:** the `ovf_cnt` port exists.
  - 8-bit counter, increments on every EXEC→RESP edge where `add_ovf`=1.
  - Saturates at 255.
  - Cleared only by reset.
- **Undefined:** no port, no counter logic. All other behaviour is identical.

## Test plan
- **Single add:** `req0`, a0=4'b0100, b0=4'b0011, op0=0 → `ack0` 2 cycles after capture edge, `sum`=4'b0111, `ovf`=0, `rsp_id`=0.
- **Overflow add:** `req1`, a1=4'b0111, b1=4'b0010, op1=0 → `ack1`, `sum`=4'b1001, `ovf`=1, `rsp_id`=1. With `RCA_ARB_OVF_CNT_EN`, `ovf_cnt`=1.
- **Subtract:**
  - `req0`, a0=4'b1011, b0=4'b0100, op0=1 → `sum`=4'b0111, `ovf`=1.
  - Then a0=4'b1011, b0=4'b1100, op0=1 → `sum`=4'b1111, `ovf`=0.
- **Tie and fairness:** `req0` and `req1` held high from reset for 4 transactions (FIRST_PRIO=0) → ack order 0,1,0,1, each ack one cycle wide, acks 3 cycles apart. `add_*` stay stable through each EXEC cycle.
- **Reset mid-op:** assert `rst_n`=0 during EXEC → no ack, all outputs at reset values. After release, a new `req1` completes normally.
- **Counter saturation (macro on):** 260 overflowing operations (7+2) → `ovf_cnt`=255.
